probe_readout_ctrl: RTL and testbench

PROBE_READOUT_CTRL -- requirements
Module: probe_readout_ctrl

---
 rtl/probe_readout_ctrl_if.sv | 33 +++
 rtl/probe_readout_ctrl.sv | 167 ++++++++++++++++
 tb/tb_probe_readout_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/probe_readout_ctrl_if.sv
// probe_readout_ctrl_if: spike input, readout request and readout stream
// signals of probe_readout_ctrl, bundled for the block and its driver.
// master = the side that drives spikes and requests and consumes words.
// slave  = probe_readout_ctrl itself.
interface probe_readout_ctrl_if #(
  parameter int NEURON_ID_WIDTH = 7,
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int OUT_WIDTH       = 16
) ();
  logic [NEURON_ID_WIDTH:0]   active_neuron;
  logic                       spike_valid;
  logic [NEURON_ID_WIDTH-1:0] spike_id;
  logic [TEN_DATA_WIDTH-1:0]  spike_val;
  logic                       clear;
  logic                       rd_req;
  logic [OUT_WIDTH-1:0]       outs;
  logic                       out_valid;
  logic                       out_ready;
  logic                       read_done;
  logic                       busy;

  modport master (
    output active_neuron, spike_valid, spike_id, spike_val, clear, rd_req,
    output out_ready,
    input  outs, out_valid, read_done, busy
  );

  modport slave (
    input  active_neuron, spike_valid, spike_id, spike_val, clear, rd_req,
    input  out_ready,
    output outs, out_valid, read_done, busy
  );
endinterface

// File: rtl/probe_readout_ctrl.sv
// probe_readout_ctrl: keeps a live bit per neuron that flips on every
// non-zero spike, snapshots it on request and streams the snapshot out as
// OUT_WIDTH-bit words under a valid/ready handshake.
// Optional feature macro PROBE_FLIPCNT_EN: a saturating toggle counter is
// latched at snapshot time and appended as one trailer word.
module probe_readout_ctrl #(
  parameter int NUM_NEURON      = 128,
  parameter int NEURON_ID_WIDTH = 7,
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int OUT_WIDTH       = 16
) (
  input  logic               clk,
  input  logic               reset_l,
  probe_readout_ctrl_if.slave bus
);

  localparam int MAX_WORDS = (NUM_NEURON + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int KW        = $clog2(MAX_WORDS + 2);
  localparam int NW        = $clog2(NUM_NEURON + 1);

  typedef enum logic [1:0] {TRACK, SNAP, STREAM, DONE} state_e;

  state_e                 state_q;
  logic [NUM_NEURON-1:0]  states_q;
  logic [NUM_NEURON-1:0]  snap_q;
  logic [NW-1:0]          n_q;
  logic [KW-1:0]          nwords_q;
  logic [KW-1:0]          k_q;
  logic [OUT_WIDTH-1:0]   outs_q;
  logic                   out_valid_q;
  logic                   read_done_q;
  logic                   busy_q;

  logic                   toggle;
  logic [NW-1:0]          n_d;
  logic [KW-1:0]          nwords_d;
  logic [KW-1:0]          k_d;
  logic [KW-1:0]          last_k;
  logic [OUT_WIDTH-1:0]   outs_d;

`ifdef PROBE_FLIPCNT_EN
  logic [OUT_WIDTH-1:0]   cnt_q;
  logic [OUT_WIDTH-1:0]   cnt_snap_q;
`endif

  // Snapshot word k with every bit at or beyond the latched count masked off;
  // shifting past the top of the vector yields zeros, so k never overruns.
  function automatic logic [OUT_WIDTH-1:0] snap_word(
    input logic [KW-1:0]         k,
    input logic [NUM_NEURON-1:0] snap,
    input logic [NW-1:0]         n
  );
    logic [NUM_NEURON-1:0] sh;
    logic [OUT_WIDTH-1:0]  w;
    sh = snap >> (int'(k) * OUT_WIDTH);
    w  = '0;
    for (int i = 0; i < OUT_WIDTH; i++)
      w[i] = sh[i] && ((int'(k) * OUT_WIDTH + i) < int'(n));
    return w;
  endfunction

  // Accepted toggle, effective neuron count and next output word.
  always_comb begin
    toggle = bus.spike_valid && (bus.spike_val != '0) &&
             ({1'b0, bus.spike_id} < bus.active_neuron) &&
             (int'(bus.spike_id) < NUM_NEURON) && !bus.clear;
    if (bus.active_neuron == '0 || int'(bus.active_neuron) > NUM_NEURON)
      n_d = NW'(NUM_NEURON);
    else
      n_d = NW'(bus.active_neuron);
    nwords_d = KW'((int'(n_d) + OUT_WIDTH - 1) / OUT_WIDTH);
    k_d      = (state_q == SNAP) ? '0 : k_q + KW'(1);
    outs_d   = snap_word(k_d, snap_q, n_q);
`ifdef PROBE_FLIPCNT_EN
    last_k   = nwords_q;
    if (k_d == nwords_q)
      outs_d = cnt_snap_q;
`else
    last_k   = nwords_q - KW'(1);
`endif
  end

  // Live probe bits: clear dominates, otherwise flip the spiking neuron.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)
      states_q <= '1;
    else if (bus.clear)
      states_q <= '1;
    else if (toggle)
      states_q[bus.spike_id] <= ~states_q[bus.spike_id];
  end

  // Readout FSM with registered stream outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= TRACK;
      snap_q      <= '1;
      n_q         <= NW'(NUM_NEURON);
      nwords_q    <= KW'(MAX_WORDS);
      k_q         <= '0;
      outs_q      <= '0;
      out_valid_q <= 1'b0;
      read_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        TRACK: begin
          read_done_q <= 1'b0;
          if (bus.rd_req) begin
            snap_q   <= states_q;
            n_q      <= n_d;
            nwords_q <= nwords_d;
            busy_q   <= 1'b1;
            state_q  <= SNAP;
          end
        end
        SNAP: begin
          k_q         <= '0;
          outs_q      <= outs_d;
          out_valid_q <= 1'b1;
          state_q     <= STREAM;
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (k_q == last_k) begin
              outs_q      <= '0;
              out_valid_q <= 1'b0;
              read_done_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              k_q    <= k_d;
              outs_q <= outs_d;
            end
          end
        end
        DONE: begin
          read_done_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= TRACK;
        end
        default: state_q <= TRACK;
      endcase
    end
  end

`ifdef PROBE_FLIPCNT_EN
  // Saturating toggle counter; restarts at snapshot, the snapshot-cycle
  // toggle belongs to the next read.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q      <= '0;
      cnt_snap_q <= '0;
    end else if (state_q == TRACK && bus.rd_req) begin
      cnt_snap_q <= cnt_q;
      cnt_q      <= toggle ? OUT_WIDTH'(1) : '0;
    end else if (toggle && cnt_q != '1) begin
      cnt_q <= cnt_q + OUT_WIDTH'(1);
    end
  end
`endif

  assign bus.outs      = outs_q;
  assign bus.out_valid = out_valid_q;
  assign bus.read_done = read_done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_probe_readout_ctrl.sv
// tb_probe_readout_ctrl: directed vectors for probe_readout_ctrl with
// hand-computed expected words; trailer words are expected only when
// PROBE_FLIPCNT_EN is defined.
module tb_probe_readout_ctrl;

  logic clk;
  logic reset_l;
  int   n_vec;
  int   n_miss;
  int   flips;
  logic [15:0] exp_words[$];

  probe_readout_ctrl_if #(.NEURON_ID_WIDTH(7), .TEN_DATA_WIDTH(2), .OUT_WIDTH(16)) bus ();

  probe_readout_ctrl #(
    .NUM_NEURON(128), .NEURON_ID_WIDTH(7), .TEN_DATA_WIDTH(2), .OUT_WIDTH(16)
  ) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) exp_words.push_back(v);
  endtask

  task automatic spike(input int id, input int val);
    bus.spike_valid = 1'b1;
    bus.spike_id    = 7'(id);
    bus.spike_val   = 2'(val);
    if (val != 0 && id < int'(bus.active_neuron)) flips++;
    tick();
    bus.spike_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // Issue one read and check every word, its timing and the end pulse.
  task automatic read_chk(input string tag, input int stall_k, input int stall_n,
                          input int spk_id);
    int nexp;
`ifdef PROBE_FLIPCNT_EN
    exp_words.push_back(16'(flips));
`endif
    flips = 0;
    bus.rd_req = 1'b1;
    if (spk_id >= 0) begin
      bus.spike_valid = 1'b1;
      bus.spike_id    = 7'(spk_id);
      bus.spike_val   = 2'd1;
      if (spk_id < int'(bus.active_neuron)) flips = 1;
    end
    tick();
    bus.rd_req      = 1'b0;
    bus.spike_valid = 1'b0;
    chk({tag, " snap busy"}, bus.busy, 1);
    chk({tag, " snap valid"}, bus.out_valid, 0);
    tick();
    nexp = exp_words.size();
    for (int i = 0; i < nexp; i++) begin
      if (i == stall_k) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk($sformatf("%s hold w%0d s%0d", tag, i, s), bus.outs, exp_words[i]);
          chk($sformatf("%s hold vld%0d s%0d", tag, i, s), bus.out_valid, 1);
          tick();
        end
        bus.out_ready = 1'b1;
      end
      chk($sformatf("%s w%0d", tag, i), bus.outs, exp_words[i]);
      chk($sformatf("%s vld%0d", tag, i), bus.out_valid, 1);
      tick();
    end
    chk({tag, " read_done"}, bus.read_done, 1);
    chk({tag, " end valid"}, bus.out_valid, 0);
    tick();
    chk({tag, " done pulse width"}, bus.read_done, 0);
    chk({tag, " idle busy"}, bus.busy, 0);
    exp_words.delete();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    flips  = 0;
    reset_l           = 1'b0;
    bus.active_neuron = 8'd128;
    bus.spike_valid   = 1'b0;
    bus.spike_id      = '0;
    bus.spike_val     = '0;
    bus.clear         = 1'b0;
    bus.rd_req        = 1'b0;
    bus.out_ready     = 1'b1;
    #1;
    chk("rst outs", bus.outs, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst read_done", bus.read_done, 0);
    chk("rst busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
    tick();
    chk("idle busy", bus.busy, 0);

    // Full 128-neuron read of the reset pattern.
    push_n(16'hFFFF, 8);
    read_chk("full", -1, 0, -1);

    // Spike on 3 flips, zero-valued spike on 20 is ignored.
    spike(3, 1);
    spike(20, 0);
    exp_words.push_back(16'hFFF7);
    push_n(16'hFFFF, 7);
    read_chk("spk3", -1, 0, -1);

    // 20 active: id 25 ignored, id 19 accepted, upper bits masked.
    do_clear();
    bus.active_neuron = 8'd20;
    spike(25, 1);
    spike(19, 1);
    exp_words.push_back(16'hFFFF);
    exp_words.push_back(16'h0007);
    read_chk("act20", -1, 0, -1);
    spike(19, 1);
    exp_words.push_back(16'hFFFF);
    exp_words.push_back(16'h000F);
    read_chk("act20b", -1, 0, -1);
    bus.active_neuron = 8'd128;
    push_n(16'hFFFF, 8);
    read_chk("id25 kept", -1, 0, -1);

    // 40 active with a 3-cycle stall on word 1.
    bus.active_neuron = 8'd40;
    exp_words.push_back(16'hFFFF);
    exp_words.push_back(16'hFFFF);
    exp_words.push_back(16'h00FF);
    read_chk("stall", 1, 3, -1);

    // Spike in the request cycle is excluded from this snapshot only.
    bus.active_neuron = 8'd128;
    push_n(16'hFFFF, 8);
    read_chk("rdcyc", -1, 0, 5);
    exp_words.push_back(16'hFFDF);
    push_n(16'hFFFF, 7);
    read_chk("rdcyc2", -1, 0, -1);

    // Clear beats a same-cycle spike; active 0 reads as all neurons.
    bus.clear       = 1'b1;
    bus.spike_valid = 1'b1;
    bus.spike_id    = 7'd0;
    bus.spike_val   = 2'd1;
    tick();
    bus.clear       = 1'b0;
    bus.spike_valid = 1'b0;
    bus.active_neuron = 8'd0;
    push_n(16'hFFFF, 8);
    read_chk("clrwin act0", -1, 0, -1);

    // Four accepted toggles then two reads (trailer 4 then 0 with counter).
    bus.active_neuron = 8'd128;
    spike(1, 1);
    spike(2, 3);
    spike(1, 2);
    spike(2, 1);
    push_n(16'hFFFF, 8);
    read_chk("cnt4", -1, 0, -1);
    push_n(16'hFFFF, 8);
    read_chk("cnt0", -1, 0, -1);

    // Reset in the middle of a stream aborts without a done pulse.
    spike(7, 1);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    chk("abort w0", bus.outs, 16'hFF7F);
    tick();
    chk("abort w1", bus.outs, 16'hFFFF);
    reset_l = 1'b0;
    #1;
    chk("abort valid", bus.out_valid, 0);
    chk("abort busy", bus.busy, 0);
    chk("abort outs", bus.outs, 0);
    chk("abort done", bus.read_done, 0);
    flips = 0;
    tick();
    reset_l = 1'b1;
    tick();
    chk("post abort done", bus.read_done, 0);
    chk("post abort busy", bus.busy, 0);
    bus.active_neuron = 8'd16;
    exp_words.push_back(16'hFFFF);
    read_chk("post abort", -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
